// File: rtl/register_readback_if.sv
// Host read port of register_readback: asynchronous read strobes in, registered byte stream out.
interface register_readback_if;
  logic       rd_enable;
  logic       rd_phase;
  logic [3:0] rd_address;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rd_error;
  logic [3:0] err_count;
  logic       parity_out;

  modport master (output rd_enable, rd_phase, rd_address,
                  input  data_out, data_valid, rd_error, err_count, parity_out);
  modport slave  (input  rd_enable, rd_phase, rd_address,
                  output data_out, data_valid, rd_error, err_count, parity_out);
endinterface

// File: rtl/register_readback.sv
// Two-byte register read-back engine driven by an asynchronous host enable/phase strobe pair.
// Define READBACK_PARITY_EN to add a registered even-parity bit alongside data_out.
module register_readback #(
  parameter int NUM_REGS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REGS*16-1:0] registers_flat,
  register_readback_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, MSB, LSB, ERR} state_t;

  state_t      r_state;
  logic [1:0]  r_en_sync;
  logic [1:0]  r_ph_sync;
  logic        r_en_prev;
  logic        r_ph_prev;
  logic [15:0] r_snap;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_rd_error;
  logic [3:0]  r_err_count;

  logic        w_en;
  logic        w_ph;
  logic        w_en_rise;
  logic        w_en_fall;
  logic        w_ph_rise;
  logic        w_ph_fall;
  logic        w_start_ok;
  logic [15:0] w_sel;
  logic [7:0]  w_data_next;
  logic [3:0]  w_err_next;

  // Two-flop synchronizers plus one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_sync <= '0;
      r_ph_sync <= '0;
      r_en_prev <= 1'b0;
      r_ph_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value; blocking would collapse the chain.
      r_en_sync <= {r_en_sync[0], bus.rd_enable};
      r_ph_sync <= {r_ph_sync[0], bus.rd_phase};
      r_en_prev <= r_en_sync[1];
      r_ph_prev <= r_ph_sync[1];
    end
  end

  assign w_en      = r_en_sync[1];
  assign w_ph      = r_ph_sync[1];
  assign w_en_rise = w_en & ~r_en_prev;
  assign w_en_fall = ~w_en & r_en_prev;
  assign w_ph_rise = w_ph & ~r_ph_prev;
  assign w_ph_fall = ~w_ph & r_ph_prev;

  always_comb begin
    // NOTE: default first so an address matching no register cannot infer a latch.
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(bus.rd_address) == i) w_sel = registers_flat[16*i +: 16];
    end
  end

  assign w_start_ok = w_ph && (int'(bus.rd_address) < NUM_REGS);
  assign w_err_next = (r_err_count == 4'hF) ? 4'hF : r_err_count + 4'd1;

  // Next byte on data_out; shared by the data register and the optional parity flop.
  always_comb begin
    w_data_next = r_data_out;
    case (r_state)
      IDLE:    if (w_en_rise && w_start_ok) w_data_next = w_sel[15:8];
      MSB:     if (w_en_fall) w_data_next = '0;
               else if (w_ph_fall) w_data_next = r_snap[7:0];
      LSB:     if (w_en_fall || w_ph_rise) w_data_next = '0;
      default: w_data_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the snapshot is reset too, so no stale or X byte can reach data_out after reset.
      r_state      <= IDLE;
      r_snap       <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_rd_error   <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_data_out <= w_data_next;
      case (r_state)
        IDLE: if (w_en_rise) begin
          if (w_start_ok) begin
            r_snap       <= w_sel;
            r_data_valid <= 1'b1;
            r_state      <= MSB;
          end else begin
            r_rd_error  <= 1'b1;
            r_err_count <= w_err_next;
            r_state     <= ERR;
          end
        end
        MSB: if (w_en_fall) begin
          // Host dropped enable before the low byte: aborted read.
          r_data_valid <= 1'b0;
          r_err_count  <= w_err_next;
          r_state      <= IDLE;
        end else if (w_ph_fall) begin
          r_state <= LSB;
        end
        LSB: if (w_en_fall) begin
          r_data_valid <= 1'b0;
          r_state      <= IDLE;
        end else if (w_ph_rise) begin
          r_data_valid <= 1'b0;
          r_rd_error   <= 1'b1;
          r_err_count  <= w_err_next;
          r_state      <= ERR;
        end
        ERR: if (w_en_fall) begin
          r_rd_error <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.rd_error   = r_rd_error;
  assign bus.err_count  = r_err_count;

`ifdef READBACK_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity <= 1'b0;
    else        r_parity <= ^w_data_next;
  end

  assign bus.parity_out = r_parity;
`else
  assign bus.parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_register_readback.sv
// Self-checking bench for register_readback: directed literal cases plus random host traffic
// compared every cycle against a transaction-level model.
module tb_register_readback;
  localparam int NUM_REGS = 2;
`ifdef READBACK_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic [3:0] cnt;
    logic       par;
  } outs_t;
  typedef struct {
    int    eff;
    outs_t o;
  } pend_t;
  typedef enum {M_IDLE, M_HI, M_LO, M_ERR} mode_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NUM_REGS*16-1:0] registers_flat;
  logic [15:0]            regs [NUM_REGS];

  register_readback_if bus ();

  register_readback #(.NUM_REGS(NUM_REGS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .registers_flat (registers_flat),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    registers_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) registers_flat[16*i +: 16] = regs[i];
  end

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    started = 1'b0;
  outs_t dut_o;
  outs_t cur = '0;
  pend_t pq[$];
  pend_t pe;

  // Transaction-level model state.
  mode_t       m_mode = M_IDLE;
  logic        m_en = 1'b0;
  logic        m_ph = 1'b0;
  logic [15:0] m_snap = '0;
  int          m_errs = 0;
  outs_t       m_out = '0;

  assign dut_o = {bus.data_out, bus.data_valid, bus.rd_error, bus.err_count, bus.parity_out};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_error();
    m_errs++;
    m_out.cnt = (m_errs > 15) ? 4'd15 : 4'(m_errs);
  endtask

  // Applies one host pin change to the model; the DUT shows the result three edges later.
  task automatic model_apply(input logic en, input logic ph, input logic [3:0] addr);
    logic en_up, en_dn, ph_up, ph_dn;
    en_up = en & ~m_en;
    en_dn = ~en & m_en;
    ph_up = ph & ~m_ph;
    ph_dn = ~ph & m_ph;
    case (m_mode)
      M_IDLE: if (en_up) begin
        if (int'(addr) < NUM_REGS && ph) begin
          m_snap      = regs[int'(addr)];
          m_out.data  = m_snap[15:8];
          m_out.valid = 1'b1;
          m_mode      = M_HI;
        end else begin
          m_out.err = 1'b1;
          model_error();
          m_mode = M_ERR;
        end
      end
      M_HI: if (en_dn) begin
        m_out.data  = 8'h00;
        m_out.valid = 1'b0;
        model_error();
        m_mode = M_IDLE;
      end else if (ph_dn) begin
        m_out.data = m_snap[7:0];
        m_mode     = M_LO;
      end
      M_LO: if (en_dn) begin
        m_out.data  = 8'h00;
        m_out.valid = 1'b0;
        m_mode      = M_IDLE;
      end else if (ph_up) begin
        m_out.data  = 8'h00;
        m_out.valid = 1'b0;
        m_out.err   = 1'b1;
        model_error();
        m_mode = M_ERR;
      end
      M_ERR: if (en_dn) begin
        m_out.err = 1'b0;
        m_mode    = M_IDLE;
      end
    endcase
    m_out.par = PAR_ON ? ^m_out.data : 1'b0;
    m_en = en;
    m_ph = ph;
    pe.eff = cyc + 3;
    pe.o   = m_out;
    pq.push_back(pe);
  endtask

  // Called #1 after a rising edge; returns #1 after the n-th following rising edge.
  task automatic drive(input logic en, input logic ph, input logic [3:0] addr, input int n);
    bus.rd_address = addr;
    bus.rd_enable  = en;
    bus.rd_phase   = ph;
    model_apply(en, ph, addr);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    rst_n         = 1'b0;
    bus.rd_enable = 1'b0;
    bus.rd_phase  = 1'b0;
    pq.delete();
    m_mode = M_IDLE;
    m_en   = 1'b0;
    m_ph   = 1'b0;
    m_errs = 0;
    m_out  = '0;
    cur    = '0;
    #2;
    if (chk) begin
      check("rst_mid_data", bus.data_out, 0);
      check("rst_mid_valid", bus.data_valid, 0);
      check("rst_mid_err", bus.rd_error, 0);
      check("rst_mid_cnt", bus.err_count, 0);
      check("rst_mid_par", bus.parity_out, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (started) begin
      while (pq.size() > 0 && pq[0].eff <= cyc) begin
        pe  = pq.pop_front();
        cur = pe.o;
      end
      check($sformatf("cycle%0d", cyc), 32'(dut_o), 32'(cur));
    end
  end

  initial begin
    bus.rd_enable  = 1'b0;
    bus.rd_phase   = 1'b0;
    bus.rd_address = 4'd0;
    regs[0] = 16'hA55A;
    regs[1] = 16'h0701;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;

    check("rst_data", bus.data_out, 0);
    check("rst_valid", bus.data_valid, 0);
    check("rst_cnt", bus.err_count, 0);
    check("rst_par", bus.parity_out, 0);

    // Normal read of 0xA55A.
    drive(1, 1, 0, 4);
    check("norm_msb", {bus.data_valid, bus.data_out}, 9'h1A5);
    drive(1, 0, 0, 4);
    check("norm_lsb", {bus.data_valid, bus.data_out}, 9'h15A);
    drive(0, 0, 0, 4);
    check("norm_end", {bus.data_valid, bus.data_out}, 9'h000);
    check("norm_cnt", bus.err_count, 0);

    // Parity bytes of 0x0701.
    drive(1, 1, 1, 4);
    check("par_msb", {bus.parity_out, bus.data_out}, {PAR_ON, 8'h07});
    drive(1, 0, 1, 4);
    check("par_lsb", {bus.parity_out, bus.data_out}, {PAR_ON, 8'h01});
    drive(0, 0, 1, 4);

    // Upstream write during the MSB phase must not reach the LSB byte.
    regs[1] = 16'h1234;
    drive(1, 1, 1, 4);
    check("snap_msb", bus.data_out, 8'h12);
    regs[1] = 16'hFFFF;
    drive(1, 0, 1, 4);
    check("snap_lsb", bus.data_out, 8'h34);
    drive(0, 0, 1, 4);

    // Start with phase low.
    drive(1, 0, 0, 4);
    check("bad_start", {bus.rd_error, bus.err_count}, 5'h11);
    drive(0, 0, 0, 4);
    check("bad_clear", bus.rd_error, 0);

    // Out-of-range address.
    drive(1, 1, 5, 4);
    check("oor", {bus.rd_error, bus.data_valid, bus.data_out, bus.err_count}, {2'b10, 8'h00, 4'd2});
    drive(0, 0, 5, 4);

    // Abort in MSB.
    drive(1, 1, 0, 4);
    drive(0, 1, 0, 4);
    check("abort", {bus.data_valid, bus.data_out, bus.err_count}, {1'b0, 8'h00, 4'd3});
    drive(0, 0, 0, 2);

    // Reset during LSB.
    drive(1, 1, 0, 4);
    drive(1, 0, 0, 4);
    check("pre_rst_lsb", bus.data_out, 8'h5A);
    do_reset(1'b1);

    // Counter saturation.
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 5, 3);
      drive(0, 0, 5, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("sat_cnt", {bus.rd_error, bus.err_count}, 5'h0F);

    // Random host traffic.
    for (int k = 0; k < 600; k++) begin
      int         r;
      logic       ne, np, rise;
      logic [3:0] addr;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset(1'b0);
      end else begin
        if (r < 15) regs[$urandom_range(0, NUM_REGS-1)] = 16'($urandom);
        do begin
          ne = 1'($urandom_range(0, 1));
          np = 1'($urandom_range(0, 1));
        end while (ne == bus.rd_enable && np == bus.rd_phase);
        rise = ne & ~bus.rd_enable;
        if (rise && $urandom_range(0, 3) != 0) np = 1'b1;
        addr = rise ? 4'($urandom_range(0, 3)) : bus.rd_address;
        drive(ne, np, addr, rise ? 3 + $urandom_range(0, 2) : 1 + $urandom_range(0, 2));
      end
    end
    repeat (4) @(posedge clk);
    #1;
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_readback.md
REGISTER_READBACK -- requirements
Module: register_readback

Interface
REQ-001 SHALL have parameter NUM_REGS, default 2, the number of 16-bit registers presented on registers_flat.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port rd_enable, input, 1, host read strobe; asynchronous to clk.
REQ-005 SHALL have port rd_phase, input, 1, host byte select (1 = MSB phase, 0 = LSB phase); asynchronous to clk.
REQ-006 SHALL have port rd_address, input, 4, index of the register to read.
REQ-007 SHALL have port registers_flat, input, NUM_REGS*16, the register file written by the upstream write stage; register i occupies bits [16*i+15:16*i].
REQ-008 SHALL have port data_out, output, 8, the read-back byte.
REQ-009 SHALL have port data_valid, output, 1, high while data_out holds a valid byte.
REQ-010 SHALL have port rd_error, output, 1, high while the transaction is in the error state.
REQ-011 SHALL have port err_count, output, 4, saturating count of protocol errors.
REQ-012 SHALL have port parity_out, output, 1, even parity of data_out (see Configuration).

Function
REQ-013 SHALL pass rd_enable and rd_phase through the codebase's two-flop synchronizer and SHALL detect edges by comparing each synchronized signal with its value one clk earlier.
REQ-014 SHALL implement four states: IDLE, MSB, LSB, ERR.
REQ-015 IDLE, rising rd_enable with rd_phase=1: SHALL snapshot register[rd_address] into a 16-bit holding register, drive data_out = snapshot[15:8], set data_valid=1, and go to MSB.
REQ-016 IDLE, rising rd_enable with rd_phase=0: SHALL go to ERR, set rd_error=1, and increment err_count.
REQ-017 IDLE, rd_address >= NUM_REGS on rising rd_enable: SHALL go to ERR, increment err_count, and keep data_out=0.
REQ-018 MSB, falling rd_phase: SHALL drive data_out = snapshot[7:0] and go to LSB.
REQ-019 MSB, falling rd_enable: SHALL go to IDLE, clear data_out and data_valid, and increment err_count (aborted read); this SHALL take priority over a simultaneous rd_phase fall.
REQ-020 LSB, falling rd_enable: SHALL go to IDLE and clear data_out and data_valid; this is a normal completion with no error.
REQ-021 LSB, rising rd_phase: SHALL go to ERR, clear data_out and data_valid, set rd_error, and increment err_count.
REQ-022 ERR: SHALL hold rd_error=1 until rd_enable falls, then go to IDLE and clear rd_error.
REQ-023 The snapshot SHALL isolate data_out from upstream writes to registers_flat made during a transaction.
REQ-024 Latency: data_out SHALL update on the 3rd rising clk edge after a pin transition that meets setup (2 edges in the synchronizer plus 1 edge for the state update).
REQ-025 err_count SHALL saturate at 15 and SHALL never wrap.
REQ-026 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 On rst_n low, the block SHALL immediately enter IDLE and clear data_out, data_valid, rd_error, err_count, parity_out, the snapshot, the synchronizer flops and the edge-detect flops.
REQ-028 Reset asserted mid-transaction SHALL abort without any error count; after release, a new transaction SHALL require a fresh rising edge on rd_enable.

Configuration
REQ-029 With macro READBACK_PARITY_EN defined, parity_out SHALL equal the XOR of data_out's 8 bits, registered in the same cycle as data_out.
REQ-030 Without READBACK_PARITY_EN, parity_out SHALL be tied to 0 and no parity logic SHALL be present.

Verification
REQ-031 Normal read: reg0=0xA55A, rd_address=0, enable rises with phase=1, then phase falls, then enable falls -> data_out 0xA5, then 0x5A, then 0x00; data_valid high through both bytes; err_count=0.
REQ-032 Snapshot: start a read of reg1=0x1234, then upstream writes reg1=0xFFFF during the MSB phase -> LSB reads 0x34.
REQ-033 Bad start: enable rises with phase=0 -> rd_error=1 and err_count=1; enable falls -> IDLE, rd_error=0.
REQ-034 Out-of-range read: rd_address=5 -> ERR, data_out=0x00, err_count increments; 16 such errors -> err_count stays at 15.
REQ-035 Abort and reset: enable falls in MSB -> IDLE, err_count+1; separately, rst_n pulsed during LSB -> all outputs 0 and err_count 0.
REQ-036 With READBACK_PARITY_EN defined, reading 0x0701 -> parity_out 1 with 0x07, then 1 with 0x01; without the macro -> parity_out constant 0.
